// File: rtl/spi_rdata_tx.sv
// SPI mode-0 read-path transmitter: decodes the header byte from the MOSI
// deserializer and streams auto-incrementing register bytes out on MISO.
module spi_rdata_tx #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              spi_clk,
    input  logic              full_rstn,
    input  logic [DATA_W-1:0] byte_deser,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              miso,
    output logic              miso_oe,
    output logic              rd_load
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_READ,
        ST_WRITE
    } state_e;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              byte_done_q, byte_done_d;
    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              rd_load_q, rd_load_d;
    logic              hdr_is_write;
    logic [ADDR_W-1:0] hdr_addr;

    assign hdr_is_write = byte_deser[DATA_W-1];
    assign hdr_addr     = byte_deser[ADDR_W-1:0];

    // Rise domain: byte_done marks the half-period after the last bit of a byte.
    always_comb begin
        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        byte_done_d = (bit_cnt_q == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        next_addr_d = next_addr_q;
        rd_load_d   = rd_load_q;
        case (state_q)
            ST_HDR: begin
                if (byte_done_q) begin
                    if (hdr_is_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        shift_d     = rdata;
                        next_addr_d = hdr_addr + ADDR_W'(1);
                        rd_load_d   = 1'b1;
                        state_d     = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (byte_done_q) begin
                    shift_d     = rdata;
                    next_addr_d = next_addr_q + ADDR_W'(1);
                    rd_load_d   = 1'b1;
                end else begin
                    shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                    rd_load_d = 1'b0;
                end
            end
            ST_WRITE: begin
                rd_load_d = 1'b0;
            end
            default: begin
                state_d   = ST_HDR;
                rd_load_d = 1'b0;
            end
        endcase
    end

    // Fall domain: MISO changes half a period before the master samples it.
    always_ff @(negedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            state_q     <= ST_HDR;
            shift_q     <= '0;
            next_addr_q <= '0;
            rd_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            next_addr_q <= next_addr_d;
            rd_load_q   <= rd_load_d;
        end
    end

    assign rd_addr = (state_q == ST_HDR) ? hdr_addr : next_addr_q;
    assign miso    = (state_q == ST_READ) && shift_q[DATA_W-1];
    assign miso_oe = (state_q == ST_READ);
    assign rd_load = rd_load_q;

endmodule

// File: tb/tb_spi_rdata_tx.sv
// Directed bench for spi_rdata_tx: the bench plays SPI master, MOSI deserializer
// and register file, and scoreboards the bytes expected back on MISO.
module tb_spi_rdata_tx;

    logic       spi_clk;
    logic       cs_active;
    logic       rstn;
    logic       full_rstn;
    logic [7:0] byte_deser;
    logic [7:0] rdata;
    logic [6:0] rd_addr;
    logic       miso;
    logic       miso_oe;
    logic       rd_load;

    logic [7:0] regs [128];
    logic [7:0] exp_q [$];
    logic [6:0] mid_rd_addr;
    int         n_compared   = 0;
    int         n_mismatched = 0;

    assign full_rstn = cs_active & rstn;
    assign rdata     = regs[rd_addr];

    spi_rdata_tx #(
        .ADDR_W(7),
        .DATA_W(8)
    ) dut (
        .spi_clk    (spi_clk),
        .full_rstn  (full_rstn),
        .byte_deser (byte_deser),
        .rdata      (rdata),
        .rd_addr    (rd_addr),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .rd_load    (rd_load)
    );

    // One comparison point: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One SPI bit: rise (deserializer shifts in mosi), mid-high sample of rd_addr,
    // fall, then return in the low phase where fall-domain outputs are stable.
    task automatic applyStimulus(input logic mosi_bit);
        #1 spi_clk = 1'b1;
        #1 byte_deser = {byte_deser[6:0], mosi_bit};
        #2 mid_rd_addr = rd_addr;
        #2 spi_clk = 1'b0;
        #4;
    endtask

    // Release CS: outputs must drop at once, and rd_addr must follow byte_deser (HDR).
    task automatic csRelease();
        cs_active = 1'b0;
        #1;
        checkOutput("rel_miso", 8'(miso), 8'h00);
        checkOutput("rel_miso_oe", 8'(miso_oe), 8'h00);
        checkOutput("rel_rd_load", 8'(rd_load), 8'h00);
        byte_deser = 8'hAA;
        #1 checkOutput("rel_rd_addr", 8'(rd_addr), 8'h2A);
        byte_deser = 8'h00;
        #2 cs_active = 1'b1;
        #6;
    endtask

    // Read header for addr, then n_bits of read data checked bit by bit against
    // the scoreboard; MOSI carries random junk during the data phase.
    task automatic readTxn(input logic [6:0] addr, input int n_bits);
        logic [7:0] hdr;
        logic [7:0] cur;
        logic [6:0] exp_addr;
        hdr = {1'b0, addr};
        for (int j = 0; j < (n_bits + 7) / 8; j++)
            exp_q.push_back(regs[7'(addr + 7'(j))]);
        for (int r = 0; r < 8; r++) begin
            checkOutput("hdr_miso_oe", 8'(miso_oe), 8'h00);
            checkOutput("hdr_rd_load", 8'(rd_load), 8'h00);
            applyStimulus(hdr[7-r]);
        end
        checkOutput("hdr_rd_addr", 8'(mid_rd_addr), 8'(addr));
        cur = 8'h00;
        for (int i = 0; i < n_bits; i++) begin
            if (i % 8 == 0) cur = exp_q.pop_front();
            exp_addr = addr + 7'(i / 8 + 1);
            checkOutput($sformatf("miso_a%0h_b%0d", addr, i), 8'(miso), 8'(cur[7 - i % 8]));
            checkOutput("data_miso_oe", 8'(miso_oe), 8'h01);
            checkOutput("data_rd_load", 8'(rd_load), (i % 8 == 0) ? 8'h01 : 8'h00);
            checkOutput("data_rd_addr", 8'(rd_addr), 8'(exp_addr));
            applyStimulus(1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        logic [7:0] wr_hdr;
        logic [7:0] wr_data;
        spi_clk    = 1'b0;
        cs_active  = 1'b0;
        rstn       = 1'b1;
        byte_deser = 8'h00;
        for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);
        regs[7'h05] = 8'hA5;
        regs[7'h06] = 8'h3C;
        regs[7'h7F] = 8'h81;
        regs[7'h00] = 8'h42;
        regs[7'h10] = 8'hFF;
        regs[7'h20] = 8'h96;
        regs[7'h03] = 8'h5E;
        regs[7'h40] = 8'hFF;
        regs[7'h41] = 8'h80;

        // Reset state while CS is idle.
        #5;
        checkOutput("rst_miso", 8'(miso), 8'h00);
        checkOutput("rst_miso_oe", 8'(miso_oe), 8'h00);
        checkOutput("rst_rd_load", 8'(rd_load), 8'h00);
        byte_deser = 8'h33;
        #1 checkOutput("rst_rd_addr", 8'(rd_addr), 8'h33);
        byte_deser = 8'h00;
        cs_active  = 1'b1;
        #4;

        $display("[TB] read 2 bytes from 0x05");
        readTxn(7'h05, 16);
        csRelease();

        $display("[TB] read with address wrap from 0x7F");
        readTxn(7'h7F, 16);
        csRelease();

        $display("[TB] write header 0x85 with 3 data bytes");
        wr_hdr = 8'h85;
        for (int r = 0; r < 8; r++) applyStimulus(wr_hdr[7-r]);
        checkOutput("wr_hdr_rd_addr", 8'(mid_rd_addr), 8'h05);
        for (int i = 0; i < 24; i++) begin
            checkOutput("wr_outs", {5'b0, miso, miso_oe, rd_load}, 8'h00);
            checkOutput("wr_rd_addr", 8'(rd_addr), 8'h00);
            wr_data = (i < 8) ? 8'hFF : ((i < 16) ? 8'h00 : 8'h8F);
            applyStimulus(wr_data[7 - i % 8]);
        end
        checkOutput("wr_outs_end", {5'b0, miso, miso_oe, rd_load}, 8'h00);
        csRelease();

        $display("[TB] CS released mid-data, then read 0x20");
        readTxn(7'h10, 4);
        csRelease();
        readTxn(7'h20, 8);
        csRelease();

        $display("[TB] CS released after 5 header bits, then read 0x03");
        wr_hdr = 8'h5A;
        for (int r = 0; r < 5; r++) begin
            applyStimulus(wr_hdr[7-r]);
            checkOutput("abort_miso_oe", 8'(miso_oe), 8'h00);
            checkOutput("abort_rd_load", 8'(rd_load), 8'h00);
        end
        csRelease();
        readTxn(7'h03, 8);
        csRelease();

        $display("[TB] async reset mid-read with CS held");
        readTxn(7'h40, 8);
        checkOutput("pre_rst_rd_load", 8'(rd_load), 8'h01);
        checkOutput("pre_rst_miso", 8'(miso), 8'h01);
        rstn = 1'b0;
        #1;
        checkOutput("async_rst_miso", 8'(miso), 8'h00);
        checkOutput("async_rst_miso_oe", 8'(miso_oe), 8'h00);
        checkOutput("async_rst_rd_load", 8'(rd_load), 8'h00);
        byte_deser = 8'h9C;
        #1 checkOutput("async_rst_rd_addr", 8'(rd_addr), 8'h1C);
        byte_deser = 8'h00;
        #2 rstn = 1'b1;
        csRelease();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
